// File: rtl/if_pc_stage_if.sv
// Bundle between the fetch stage and its neighbours: instruction memory,
// the hazard unit, the ID-stage branch controller and the ID stage itself.
interface if_pc_stage_if;
   logic [31:0] Instr;
   logic        Stall;
   logic        Brch;
   logic        Jump;
   logic        JumpReg;
   logic [31:0] Rs;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        Redirect;

   modport master (
      input  Instr, Stall, Brch, Jump, JumpReg, Rs,
      output PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, Redirect
   );

   modport slave (
      output Instr, Stall, Brch, Jump, JumpReg, Rs,
      input  PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, Redirect
   );
endinterface

// File: rtl/if_pc_stage.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline
// register. No delay slot; a redirect squashes the same-cycle fetch.
module if_pc_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   if_pc_stage_if.master bus
);

   typedef enum logic [1:0] {
      SRC_SEQ,
      SRC_BRCH,
      SRC_JUMP,
      SRC_JREG
   } pc_src_e;

   logic [31:0] r_pc;
   logic [31:0] r_if_id_instr;
   logic [31:0] r_if_id_pcplus4;
   logic        r_if_id_valid;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_offset;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;
   logic [31:0] w_target;
   logic        w_active;
   logic        w_redirect;
   pc_src_e     w_src;

   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_offset = {{14{r_if_id_instr[15]}}, r_if_id_instr[15:0], 2'b00};
   assign w_br_target = r_if_id_pcplus4 + w_br_offset;
   assign w_j_target  = {r_if_id_pcplus4[31:28], r_if_id_instr[25:0], 2'b00};

   // A bubble in ID, a stall or reset masks every control input.
   assign w_active = r_if_id_valid & ~rst & ~bus.Stall;

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves w_src unassigned and no latch is inferred.
      w_src = SRC_SEQ;
      if (w_active) begin
         if (bus.JumpReg)   w_src = SRC_JREG;
         else if (bus.Jump) w_src = SRC_JUMP;
         else if (bus.Brch) w_src = SRC_BRCH;
      end
   end

   assign w_redirect = (w_src != SRC_SEQ);

   always_comb begin
      w_target = w_pc_plus4;
      case (w_src)
         SRC_JREG: w_target = bus.Rs;
         SRC_JUMP: w_target = w_j_target;
         SRC_BRCH: w_target = w_br_target;
         default:  w_target = w_pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         r_pc            <= RESET_PC;
         r_if_id_instr   <= NOP_INSTR;
         r_if_id_pcplus4 <= 32'd0;
         r_if_id_valid   <= 1'b0;
      end else if (bus.Stall) begin
         r_pc            <= r_pc;
         r_if_id_instr   <= r_if_id_instr;
         r_if_id_pcplus4 <= r_if_id_pcplus4;
         r_if_id_valid   <= r_if_id_valid;
      end else if (w_redirect) begin
         r_pc            <= w_target;
         r_if_id_instr   <= NOP_INSTR;
         r_if_id_pcplus4 <= 32'd0;
         r_if_id_valid   <= 1'b0;
      end else begin
         r_pc            <= w_pc_plus4;
         r_if_id_instr   <= bus.Instr;
         r_if_id_pcplus4 <= w_pc_plus4;
         r_if_id_valid   <= 1'b1;
      end
   end

   assign bus.PC            = r_pc;
   assign bus.IF_ID_Instr   = r_if_id_instr;
   assign bus.IF_ID_PCPlus4 = r_if_id_pcplus4;
   assign bus.IF_ID_Valid   = r_if_id_valid;
   assign bus.Redirect      = w_redirect;

endmodule

// File: doc/if_pc_stage.md
# if_pc_stage

Fetch-side stage of the 5-stage pipelined CPU: owns the program counter and the IF/ID pipeline register. It sits directly upstream of the ID-stage branch controller. It supplies the ID-stage instruction and PC+4 from which the branch operands and condition are decoded. It consumes the branch controller's taken/not-taken decision, together with jump and stall controls, to select the next PC and squash the wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; word-aligned
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush and reset

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- Instr  input  32  instruction memory read data for the current PC; combinational, same cycle
- Stall  input  1  hazard unit stall; holds PC and IF/ID
- Brch  input  1  branch taken, from branch controller, evaluated on the current IF/ID instruction
- Jump  input  1  j/jal in ID
- JumpReg  input  1  jr/jalr in ID
- Rs  input  32  forwarded rs value in ID, used as the jr target
- PC  output  32  current fetch address, drives instruction memory
- IF_ID_Instr  output  32  registered instruction for ID
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction
- IF_ID_Valid  output  1  0 when IF/ID holds a reset or flush bubble
- Redirect  output  1  combinational; next PC is non-sequential this cycle

## Operation
- There is no branch delay slot. A taken redirect squashes the instruction fetched in the same cycle.
- Target arithmetic is modulo 2^32, with carries discarded:
  - BrTarget = IF_ID_PCPlus4 + (sign_extend(IF_ID_Instr[15:0]) << 2)
  - JTarget = {IF_ID_PCPlus4[31:28], IF_ID_Instr[25:0], 2'b00}
  - JrTarget = Rs, used unmodified with no alignment check
- Redirect is raised only when none of rst and Stall is asserted and at least one of Brch, Jump, JumpReg is asserted.
- Redirect source priority is JumpReg > Jump > Brch. The decoder makes these exclusive; the priority is still implemented and checked.
- Next-state selection, highest priority first:
  - rst: PC <= RESET_PC; IF_ID_Instr <= NOP_INSTR; IF_ID_PCPlus4 <= 0; IF_ID_Valid <= 0.
  - Stall: PC and all IF/ID fields hold. Brch, Jump and JumpReg are ignored. The held ID instruction re-evaluates its redirect after the stall releases.
  - Redirect: PC <= selected target; IF_ID_Instr <= NOP_INSTR; IF_ID_PCPlus4 <= 0; IF_ID_Valid <= 0.
  - Otherwise: PC <= PC+4; IF_ID_Instr <= Instr; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1.
- Control inputs are ignored while IF_ID_Valid=0. A bubble never redirects, even if Brch is asserted.
- PC+4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values of the outputs:
  - PC = RESET_PC
  - IF_ID_Instr = NOP_INSTR
  - IF_ID_PCPlus4 = 0
  - IF_ID_Valid = 0
  - Redirect = 0
- rst asserted mid-operation takes effect on the next edge regardless of Stall or a redirect.
- Fetch-to-ID latency is 1 cycle. An instruction at PC is visible in IF/ID one edge later.
- Branch or jump penalty is 1 cycle: one bubble. The target instruction reaches ID 2 edges after the branch is in ID.
- Stall for N cycles holds PC and IF/ID for exactly N edges. Release resumes with no lost or duplicated instruction.
- Redirect is purely combinational from IF/ID state, Stall, Brch, Jump, JumpReg and rst. PC is a register output. Instr feeds only the IF/ID register, so there is no combinational Instr-to-output path.

## Test plan
- Reset then free-run, with Instr=PC-derived pattern: the first edge after reset release sets PC=32'h3004 and IF_ID_PCPlus4=32'h3004 with IF_ID_Valid=1; PC then advances by 4 each cycle.
- Taken branch, with IF_ID_PCPlus4=32'h3010, imm=16'hFFFE and Brch=1: next PC=32'h3008, IF_ID_Valid=0 for one cycle, and the target instruction is valid in ID 2 edges later.
- Jump and jr:
  - j with instr[25:0]=26'h0000C40 and IF_ID_PCPlus4=32'h3020 gives PC=32'h0000_3100.
  - jr with Rs=32'h0000_4000 gives PC=32'h4000.
  - Jump=JumpReg=Brch=1 together gives the Rs target.
- Stall with Brch=1: Stall=1 for 3 cycles leaves PC, IF_ID_Instr and IF_ID_PCPlus4 unchanged and Redirect=0. The cycle after release redirects to the branch target.
- Bubble immunity and wrap:
  - Brch=1 while IF_ID_Valid=0 leaves PC=PC+4 with no redirect.
  - PC forced via jr to 32'hFFFF_FFFC wraps to 32'h0000_0000 on the next edge.
- rst asserted concurrently with Stall=1 and a pending redirect: the next edge gives PC=RESET_PC and IF_ID_Valid=0.
